fft_reorder: RTL and testbench
==============================

FFT_REORDER -- requirements
Module: fft_reorder

Interface
REQ-001 Parameter N, default 64, frame length in samples (power of two, N >= 4).
REQ-002 Parameter WIDTH, default 8, bit width of each real/imaginary component.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 enable_in  input  1  input sample valid; held high for a contiguous frame of N samples (same semantics as sdf4 enable_out).
REQ-006 in_re  input  WIDTH  real part of bit-reversed-order FFT sample.
REQ-007 in_im  input  WIDTH  imaginary part of bit-reversed-order FFT sample.
REQ-008 enable_out  output  1  output sample valid, natural order.
REQ-009 out_re  output  WIDTH  real part of natural-order sample.
REQ-010 out_im  output  WIDTH  imaginary part of natural-order sample.
REQ-011 out_first  output  1  high with enable_out on sample index 0 of each frame.
REQ-012 out_last  output  1  high with enable_out on sample index N-1 of each frame.

Function
REQ-013 Storage: two banks (ping/pong) of N entries x 2*WIDTH bits; per-bank state FREE / FULL / READING.
REQ-014 Write counter wr_cnt (log2 N bits): +1 per edge with enable_in=1; cleared to 0 on any edge with enable_in=0.
REQ-015 Each accepted sample is written to wr_bank at address bitrev(wr_cnt), i.e. wr_cnt bit order reversed over log2 N bits.
REQ-016 Accepting sample with wr_cnt==N-1: wr_bank state -> FULL, wr_bank toggles, wr_cnt wraps to 0; next frame may follow with no idle cycle.
REQ-017 Aborted frame (enable_in drops before wr_cnt reaches N-1): partial data discarded, bank stays FREE, wr_bank unchanged, no output produced.
REQ-018 Reader FSM states IDLE, READ; rd_bank pointer starts at bank 0, rd_cnt (log2 N bits).
REQ-019 IDLE -> READ on the edge where rd_bank is FULL; on that edge rd_bank -> READING, rd_cnt=0.
REQ-020 READ: one memory read per cycle at sequential address rd_cnt; rd_cnt +1 per edge.
REQ-021 Final read (rd_cnt==N-1): rd_bank -> FREE, rd_bank toggles; if the new rd_bank is already FULL, go straight to READ (rd_cnt=0, no gap), else IDLE.
REQ-022 Memory read is registered: out_re/out_im/enable_out/out_first/out_last are registers valid one cycle after the read address is issued.
REQ-023 Latency: if the last sample of a frame is captured on edge E, enable_out is high with entry 0 after edge E+2, for exactly N consecutive cycles.
REQ-024 Continuous input (back-to-back frames, enable_in held high) yields continuous enable_out with no bubble between frames.
REQ-025 Write/read to the same bank in the same cycle to different addresses is legal; at equal rates a location is always read before it is overwritten by the next frame.
REQ-026 When enable_out=0, out_re/out_im hold their last value; out_first/out_last are 0.
REQ-027 Data passes unmodified: no scaling, rounding or sign change.

Reset
REQ-028 rst=1 on an edge: wr_cnt=0, rd_cnt=0, wr_bank=rd_bank=0, both banks FREE, FSM IDLE, enable_out/out_first/out_last=0, out_re/out_im=0.
REQ-029 Reset mid-frame or mid-read discards all in-flight frames; memory contents are not cleared and are never emitted without a fresh complete frame.
REQ-030 rst has priority over enable_in on the same edge; the sample presented on that edge is dropped.

Verification (N=8, WIDTH=8)
REQ-031 Single frame in_re=k, in_im=8-k for k=0..7 -> after E+2, 8 cycles out_re=0,1,...,7, out_im=8,7,...,1; out_first on cycle 0, out_last on cycle 7.
REQ-032 Three back-to-back frames (24 cycles enable_in=1) -> 24 contiguous enable_out cycles, each frame in natural order, out_first every 8th cycle.
REQ-033 Enable_in high 5 cycles, low 1, then full 8-sample frame -> exactly one output frame of 8, matching the second frame only.
REQ-034 rst pulsed during output of frame 1 with frame 2 half written -> enable_out=0 the cycle after reset, no output until a new complete frame, which emits correctly.
REQ-035 Gaps of 3 idle cycles between frames -> each frame emitted with latency 2, and enable_out low between frames.
REQ-036 Random complex data, 100 frames back-to-back, N=64 -> output equals golden bit-reverse permutation of each input frame, zero mismatches.

Source files
------------

// File: rtl/fft_reorder.sv
// Ping/pong reorder buffer: takes bit-reversed FFT output and emits it in natural order.
// Samples are scattered to bitrev(wr_cnt) on write and read back sequentially.
module fft_reorder #(
  parameter int N     = 64,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_in,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  output logic                    enable_out,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im,
  output logic                    out_first,
  output logic                    out_last
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic [1:0] {B_FREE, B_FULL, B_READING} bank_t;
  typedef enum logic {RD_IDLE, RD_READ} rd_state_t;

  logic [2*WIDTH-1:0] mem [2*N];

  logic [AW-1:0] wr_cnt;
  logic          wr_bank;
  logic [AW-1:0] rd_cnt;
  logic          rd_bank;
  bank_t         bank_st [2];
  rd_state_t     rd_state;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  // Write port: scatter each sample to its natural-order slot in wr_bank
  always_ff @(posedge clk) begin
    if (enable_in && !rst) mem[{wr_bank, bitrev(wr_cnt)}] <= {in_re, in_im};
  end

  // Control plus registered read port; the read register is the output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt     <= '0;
      wr_bank    <= 1'b0;
      rd_cnt     <= '0;
      rd_bank    <= 1'b0;
      bank_st[0] <= B_FREE;
      bank_st[1] <= B_FREE;
      rd_state   <= RD_IDLE;
      enable_out <= 1'b0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
      out_re     <= '0;
      out_im     <= '0;
    end else begin
      enable_out <= 1'b0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;

      case (rd_state)
        RD_IDLE: begin
          if (bank_st[rd_bank] == B_FULL) begin
            bank_st[rd_bank] <= B_READING;
            rd_cnt           <= '0;
            rd_state         <= RD_READ;
          end
        end
        RD_READ: begin
          enable_out       <= 1'b1;
          out_first        <= (rd_cnt == '0);
          out_last         <= (rd_cnt == LAST);
          {out_re, out_im} <= mem[{rd_bank, rd_cnt}];
          rd_cnt           <= rd_cnt + 1'b1;
          if (rd_cnt == LAST) begin
            bank_st[rd_bank] <= B_FREE;
            rd_bank          <= ~rd_bank;
            // Chain straight into the other bank when it is already waiting
            if (bank_st[~rd_bank] == B_FULL) begin
              bank_st[~rd_bank] <= B_READING;
              rd_cnt            <= '0;
            end else begin
              rd_state <= RD_IDLE;
            end
          end
        end
        default: rd_state <= RD_IDLE;
      endcase

      // Writer updates last so a completed frame is never lost to a same-edge release
      if (enable_in) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_cnt == LAST) begin
          bank_st[wr_bank] <= B_FULL;
          wr_bank          <= ~wr_bank;
        end
      end else begin
        wr_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fft_reorder.sv
// Directed bench for fft_reorder: N=8 corner cases plus a 100-frame random run at N=64.
module tb_fft_reorder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       en8;
  logic [7:0] re8, im8;
  logic       eo8, of8, ol8;
  logic [7:0] ore8, oim8;

  logic       en64;
  logic [7:0] re64, im64;
  logic       eo64, of64, ol64;
  logic [7:0] ore64, oim64;

  fft_reorder #(.N(8), .WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .enable_in(en8), .in_re(re8), .in_im(im8),
    .enable_out(eo8), .out_re(ore8), .out_im(oim8), .out_first(of8), .out_last(ol8)
  );

  fft_reorder #(.N(64), .WIDTH(8)) dut64 (
    .clk(clk), .rst(rst), .enable_in(en64), .in_re(re64), .in_im(im64),
    .enable_out(eo64), .out_re(ore64), .out_im(oim64), .out_first(of64), .out_last(ol64)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rst_q = 1'b0;
  logic mon_on = 1'b0;
  logic [7:0] prev_re, prev_im;

  typedef struct {
    int         cyc;
    logic [7:0] re;
    logic [7:0] im;
    logic       first;
    logic       last;
  } obs_t;
  obs_t q8[$];
  obs_t q64[$];

  typedef struct {
    logic [7:0] in_re;
    logic [7:0] in_im;
    logic [7:0] exp_re;
    logic [7:0] exp_im;
    logic       exp_first;
    logic       exp_last;
  } vec_t;
  vec_t tbl [8];

  logic [15:0] exp64 [6400];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (eo8) q8.push_back('{cyc, ore8, oim8, of8, ol8});
      else begin
        chk("idle_flags", 64'({of8, ol8}), 64'(0));
        if (!rst_q) chk("idle_hold", 64'({ore8, oim8}), 64'({prev_re, prev_im}));
      end
      prev_re = ore8;
      prev_im = oim8;
      if (eo64) q64.push_back('{cyc, ore64, oim64, of64, ol64});
    end
  end

  function automatic int brev(input int v, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) if (v[i]) r |= 1 << (bits - 1 - i);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] r, input logic [7:0] i);
    en8 = 1'b1; re8 = r; im8 = i;
    tick();
  endtask

  task automatic idle8(input int n);
    en8 = 1'b0;
    repeat (n) tick();
  endtask

  // Sends natural-order values re=rb+k, im=ib+k in bit-reversed order; returns last-sample edge
  task automatic send_frame8(input logic [7:0] rb, input logic [7:0] ib, output int e);
    for (int j = 0; j < 8; j++) begin
      int k;
      k = brev(j, 3);
      send8(8'(rb + k), 8'(ib + k));
    end
    e = cyc;
  endtask

  task automatic check_frame(input string nm, input int qi, input int st0,
                             input logic [7:0] rb, input logic [7:0] ib);
    for (int k = 0; k < 8; k++) begin
      logic [7:0] er, ei;
      er = 8'(rb + k);
      ei = 8'(ib + k);
      chk(nm, 64'({32'(q8[qi+k].cyc), q8[qi+k].re, q8[qi+k].im, q8[qi+k].first, q8[qi+k].last}),
          64'({32'(st0 + k), er, ei, k == 0, k == 7}));
    end
  endtask

  initial begin
    int e, e1, r;
    int ef [3];
    int cnt;

    tbl[0] = '{8'd0, 8'd8, 8'd0, 8'd8, 1'b1, 1'b0};
    tbl[1] = '{8'd4, 8'd4, 8'd1, 8'd7, 1'b0, 1'b0};
    tbl[2] = '{8'd2, 8'd6, 8'd2, 8'd6, 1'b0, 1'b0};
    tbl[3] = '{8'd6, 8'd2, 8'd3, 8'd5, 1'b0, 1'b0};
    tbl[4] = '{8'd1, 8'd7, 8'd4, 8'd4, 1'b0, 1'b0};
    tbl[5] = '{8'd5, 8'd3, 8'd5, 8'd3, 1'b0, 1'b0};
    tbl[6] = '{8'd3, 8'd5, 8'd6, 8'd2, 1'b0, 1'b0};
    tbl[7] = '{8'd7, 8'd1, 8'd7, 8'd1, 1'b0, 1'b1};

    rst = 1'b1; en8 = 1'b0; re8 = 8'h5A; im8 = 8'hA5;
    en64 = 1'b0; re64 = '0; im64 = '0;
    tick(); tick();
    chk("rst_enable_out", 64'(eo8), 64'(0));
    chk("rst_out_re", 64'(ore8), 64'(0));
    chk("rst_out_im", 64'(oim8), 64'(0));
    chk("rst_flags", 64'({of8, ol8, eo64}), 64'(0));
    rst = 1'b0;
    prev_re = 8'h00; prev_im = 8'h00;
    mon_on = 1'b1;
    idle8(2);

    // Single frame from the vector table
    q8.delete();
    for (int j = 0; j < 8; j++) send8(tbl[j].in_re, tbl[j].in_im);
    e = cyc;
    idle8(12);
    chk("single_count", 64'(q8.size()), 64'(8));
    if (q8.size() >= 8)
      for (int j = 0; j < 8; j++)
        chk("single_vec", 64'({32'(q8[j].cyc), q8[j].re, q8[j].im, q8[j].first, q8[j].last}),
            64'({32'(e + 2 + j), tbl[j].exp_re, tbl[j].exp_im, tbl[j].exp_first, tbl[j].exp_last}));

    // Three back-to-back frames, negative-looking imaginary parts
    q8.delete();
    send_frame8(8'h10, 8'hF0, e1);
    send_frame8(8'h20, 8'hE0, e);
    send_frame8(8'h30, 8'hC8, e);
    idle8(12);
    chk("b2b_count", 64'(q8.size()), 64'(24));
    if (q8.size() >= 24) begin
      check_frame("b2b_f0", 0, e1 + 2, 8'h10, 8'hF0);
      check_frame("b2b_f1", 8, e1 + 10, 8'h20, 8'hE0);
      check_frame("b2b_f2", 16, e1 + 18, 8'h30, 8'hC8);
    end

    // Aborted partial frame followed by a complete one
    q8.delete();
    for (int j = 0; j < 5; j++) send8(8'hAA, 8'h55);
    idle8(1);
    send_frame8(8'h40, 8'h80, e);
    idle8(12);
    chk("abort_count", 64'(q8.size()), 64'(8));
    if (q8.size() >= 8) check_frame("abort_frame", 0, e + 2, 8'h40, 8'h80);

    // Reset while frame A is being emitted and frame B is half written
    q8.delete();
    send_frame8(8'h50, 8'h01, e);
    for (int j = 0; j < 4; j++) send8(8'(8'h70 + brev(j, 3)), 8'h02);
    rst = 1'b1; en8 = 1'b1; re8 = 8'hEE; im8 = 8'hEE;
    tick();
    r = cyc;
    rst = 1'b0; en8 = 1'b0;
    chk("rst_mid_enable_out", 64'(eo8), 64'(0));
    idle8(20);
    chk("rst_mid_pre_count", 64'(q8.size()), 64'(3));
    cnt = 0;
    foreach (q8[i]) if (q8[i].cyc >= r) cnt++;
    chk("rst_mid_no_output", 64'(cnt), 64'(0));
    q8.delete();
    send_frame8(8'h60, 8'h11, e);
    idle8(12);
    chk("rst_fresh_count", 64'(q8.size()), 64'(8));
    if (q8.size() >= 8) check_frame("rst_fresh_frame", 0, e + 2, 8'h60, 8'h11);

    // Frames separated by three idle cycles
    q8.delete();
    for (int f = 0; f < 3; f++) begin
      send_frame8(8'(8'h80 + 16 * f), 8'(8'h08 + 16 * f), ef[f]);
      idle8(3);
    end
    idle8(12);
    chk("gap_count", 64'(q8.size()), 64'(24));
    if (q8.size() >= 24)
      for (int f = 0; f < 3; f++)
        check_frame("gap_frame", 8 * f, ef[f] + 2, 8'(8'h80 + 16 * f), 8'(8'h08 + 16 * f));

    // N=64: 100 random back-to-back frames against a bit-reverse golden model
    q64.delete();
    for (int f = 0; f < 100; f++)
      for (int j = 0; j < 64; j++) begin
        logic [15:0] d;
        d = 16'($urandom);
        exp64[f * 64 + brev(j, 6)] = d;
        en64 = 1'b1; re64 = d[15:8]; im64 = d[7:0];
        tick();
      end
    en64 = 1'b0;
    repeat (80) tick();
    chk("n64_count", 64'(q64.size()), 64'(6400));
    if (q64.size() >= 6400)
      for (int i = 0; i < 6400; i++)
        chk("n64_sample",
            64'({32'(q64[i].cyc - q64[0].cyc), q64[i].re, q64[i].im, q64[i].first, q64[i].last}),
            64'({32'(i), exp64[i], (i % 64) == 0, (i % 64) == 63}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
